// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and a constant clog2 helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, valid/ready on both
// sides, sticky overflow when the value does not fit in NDIG digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 6,
  parameter int NDIG  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIN_W-1:0]            bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*NDIG-1:0] bcd,
  output logic                        ovf,
  output logic [NDIG-1:0]             lz_mask
);

  localparam int ACC_W = BCD_DIGIT_W * NDIG;
  localparam int CNT_W = clog2(BIN_W + 1);

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W=%0d outside 1..32", BIN_W);
  end
  if (NDIG < 1 || NDIG > 10) begin : g_bad_ndig
    $error("bin_to_bcd_seq: NDIG=%0d outside 1..10", NDIG);
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  sh_q, sh_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_adj;
  logic              ovf_q, ovf_d;
  logic [NDIG-1:0]   lz_q, lz_d;
  logic              upper_zero;

  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (acc_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (acc_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    lz_d       = lz_q;
    upper_zero = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_d    = bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          lz_d    = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The digit-MSB pushed out of the accumulator is the overflow carry.
        {acc_d, sh_d} = {acc_adj[ACC_W-2:0], sh_q, 1'b0};
        ovf_d         = ovf_q | acc_adj[ACC_W-1];
        cnt_d         = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          for (int k = NDIG - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (acc_d[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            lz_d[k]    = upper_zero & ~ovf_d;
          end
          lz_d[0] = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples
  // the pre-edge value of the others, matching real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so nothing stale is
      // ever visible on bcd/ovf/lz_mask after a reset.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      lz_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      lz_q    <= lz_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bcd       = acc_q;
  assign ovf       = ovf_q;
  assign lz_mask   = lz_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench: three converter configurations checked
// against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, ovf;
  logic [9:0] bin_v [3];
  logic [7:0] bcd0, bcd1;
  logic [15:0] bcd2;
  logic [1:0] lz0, lz1;
  logic [3:0] lz2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(6), .NDIG(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .bin(bin_v[0][5:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .bcd(bcd0), .ovf(ovf[0]), .lz_mask(lz0));

  bin_to_bcd_seq #(.BIN_W(7), .NDIG(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .bin(bin_v[1][6:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .bcd(bcd1), .ovf(ovf[1]), .lz_mask(lz1));

  bin_to_bcd_seq #(.BIN_W(10), .NDIG(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .bin(bin_v[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .bcd(bcd2), .ovf(ovf[2]), .lz_mask(lz2));

  function automatic int width_of(input int d);
    return (d == 0) ? 6 : (d == 1) ? 7 : 10;
  endfunction

  function automatic int ndig_of(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic logic [15:0] get_bcd(input int d);
    return (d == 0) ? {8'h00, bcd0} : (d == 1) ? {8'h00, bcd1} : bcd2;
  endfunction

  function automatic logic [3:0] get_lz(input int d);
    return (d == 0) ? {2'b00, lz0} : (d == 1) ? {2'b00, lz1} : lz2;
  endfunction

  // Reference model: plain decimal arithmetic.
  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] exp_bcd(input int v, input int n);
    longint m = longint'(v) % pow10(n);
    logic [15:0] r = '0;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic exp_ovf(input int v, input int n);
    return longint'(v) >= pow10(n);
  endfunction

  function automatic logic [3:0] exp_lz(input int v, input int n);
    logic [3:0] r = '0;
    if (!exp_ovf(v, n))
      for (int k = 1; k < n; k++) r[k] = longint'(v) < pow10(k);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic convert(input int d, input int v, input int hold);
    int          lat;
    logic [15:0] eb;
    string       t;
    eb = exp_bcd(v, ndig_of(d));
    t  = $sformatf("d%0d v=%0d", d, v);
    check({t, " in_ready"}, 64'(in_ready[d]), 64'd1);
    in_valid[d] = 1'b1;
    bin_v[d]    = 10'(v);
    @(negedge clk);
    in_valid[d] = 1'b0;
    bin_v[d]    = 10'($urandom);
    lat = 0;
    while (!out_valid[d] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({t, " latency"}, 64'(lat), 64'(width_of(d)));
    check({t, " bcd"}, 64'(get_bcd(d)), 64'(eb));
    check({t, " ovf"}, 64'(ovf[d]), 64'(exp_ovf(v, ndig_of(d))));
    check({t, " lz"}, 64'(get_lz(d)), 64'(exp_lz(v, ndig_of(d))));
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = 1'($urandom_range(0, 1));
      bin_v[d]    = 10'($urandom);
      @(negedge clk);
      check({t, " hold valid"}, 64'({out_valid[d], in_ready[d]}), 64'b10);
      check({t, " hold bcd"}, 64'(get_bcd(d)), 64'(eb));
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({t, " release"}, 64'({out_valid[d], in_ready[d]}), 64'b01);
    check({t, " kept bcd"}, 64'(get_bcd(d)), 64'(eb));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int rises, t0, t1, prev, bad;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) bin_v[d] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset d%0d hs", d), 64'({out_valid[d], in_ready[d]}), 64'b01);
      check($sformatf("reset d%0d bcd", d), 64'(get_bcd(d)), 64'd0);
      check($sformatf("reset d%0d ovf/lz", d), 64'({ovf[d], get_lz(d)}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed points, then exhaustive sweep of the 6-bit configuration.
    convert(0, 59, 5);
    convert(0, 7, 0);
    convert(0, 0, 1);
    for (int v = 0; v < 64; v++) convert(0, v, $urandom_range(0, 2));

    convert(1, 127, 2);
    convert(1, 99, 0);
    convert(1, 100, 0);
    for (int i = 0; i < 20; i++) convert(1, $urandom_range(0, 127), $urandom_range(0, 3));

    convert(2, 1023, 1);
    convert(2, 0, 0);
    convert(2, 9, 0);
    for (int i = 0; i < 12; i++) convert(2, $urandom_range(0, 1023), $urandom_range(0, 3));

    // Reset in the middle of a conversion.
    in_valid[0] = 1'b1;
    bin_v[0]    = 10'd59;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst hs", 64'({out_valid[0], in_ready[0]}), 64'b01);
    check("midrst bcd", 64'(bcd0), 64'd0);
    check("midrst ovf/lz", 64'({ovf[0], lz0}), 64'd0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0]) bad++;
    end
    check("midrst no result", 64'(bad), 64'd0);
    convert(0, 42, 0);

    // in_valid while reset is held is not an acceptance.
    rst         = 1'b1;
    in_valid[0] = 1'b1;
    bin_v[0]    = 10'd5;
    @(negedge clk);
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("rst blocks accept", 64'(in_ready[0]), 64'd1);

    // Back-to-back throughput on the 10-bit configuration.
    in_valid[2]  = 1'b1;
    bin_v[2]     = 10'd1023;
    out_ready[2] = 1'b1;
    rises = 0; t0 = 0; t1 = 0; prev = 0;
    for (int c = 0; c < 100 && rises < 3; c++) begin
      @(negedge clk);
      if (out_valid[2] && !prev) begin
        rises++;
        check("b2b bcd", 64'(bcd2), 64'h1023);
        if (rises == 2) t0 = c;
        if (rises == 3) begin
          t1 = c;
          in_valid[2] = 1'b0;
          check("b2b period", 64'(t1 - t0), 64'd12);
        end
      end
      prev = int'(out_valid[2]);
    end
    check("b2b results", 64'(rises), 64'd3);
    in_valid[2] = 1'b0;
    @(negedge clk);
    out_ready[2] = 1'b0;
    check("b2b idle", 64'({out_valid[2], in_ready[2]}), 64'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 6, width of the unsigned binary input; legal range 1..32.
REQ-002 SHALL have parameter NDIG, default 2, number of BCD output digits; legal range 1..10.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, bin is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block can accept a new value.
REQ-007 SHALL have port bin, input, BIN_W, unsigned binary value to convert.
REQ-008 SHALL have port out_valid, output, 1, bcd/ovf/lz_mask hold a finished result.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port bcd, output, 4*NDIG, packed digits; digit k occupies bits [4k+3:4k], digit 0 = ones.
REQ-011 SHALL have port ovf, output, 1, value exceeded 10^NDIG-1; bcd then holds the value modulo 10^NDIG.
REQ-012 SHALL have port lz_mask, output, NDIG, bit k set when digit k is a leading zero; bit 0 always 0.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL equal (state==IDLE), combinationally; no other state accepts input.
REQ-015 In IDLE, in_valid&&in_ready SHALL capture bin, clear the BCD accumulator and ovf, load iteration counter with BIN_W, and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL first add 3 to every accumulator digit >=5 (double-dabble), then shift {accumulator, binary} left by one bit; the counter decrements.
REQ-017 A 1 shifted out of the top digit SHALL set the sticky ovf bit; bits shifted out are otherwise discarded.
REQ-018 After the BIN_W-th shift the FSM SHALL enter DONE; out_valid SHALL rise exactly BIN_W cycles after the accepting edge.
REQ-019 bcd, ovf and lz_mask SHALL be registered and stable for the whole time out_valid is high.
REQ-020 In DONE, out_valid&&out_ready SHALL return the FSM to IDLE at that edge; out_valid low the next cycle. Outputs keep their last values until the next acceptance.
REQ-021 lz_mask SHALL be computed from the final digits: bit k (k>=1) set iff digits k..NDIG-1 are all zero; when ovf=1, lz_mask SHALL be all-zero.
REQ-022 in_valid during SHIFT or DONE SHALL be ignored; bin changes after acceptance SHALL not affect the result.
REQ-023 Counter width SHALL be clog2(BIN_W+1); no arithmetic beyond 4-bit digit adds.

Reset
REQ-024 On rst high at a clock edge: state IDLE, out_valid 0, bcd 0, ovf 0, lz_mask all-zero, counter 0, shift register 0.
REQ-025 rst SHALL override any handshake in the same cycle, including mid-SHIFT and DONE; no partial result is ever presented.
REQ-026 While rst is high, in_valid SHALL not cause acceptance even though in_ready may read 1.

Structure
REQ-027 Shared package bcd_pkg SHALL hold the FSM state enum, BCD_DIGIT_W=4 and the clog2 helper function.
REQ-028 Per-digit add-3 adjust SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out), instantiated NDIG times.
REQ-029 Elaboration SHALL fail on BIN_W or NDIG outside legal ranges.

Verification
REQ-030 BIN_W=6,NDIG=2: bin=59 accepted -> out_valid 6 cycles later, bcd=8'h59, ovf=0, lz_mask=2'b00.
REQ-031 BIN_W=6,NDIG=2: bin=7 -> bcd=8'h07, lz_mask=2'b10; bin=0 -> bcd=8'h00, lz_mask=2'b10; exhaustive sweep 0..63 matches reference model.
REQ-032 BIN_W=7,NDIG=2: bin=127 -> bcd=8'h27, ovf=1, lz_mask=2'b00; bin=99 -> bcd=8'h99, ovf=0.
REQ-033 Backpressure: out_ready low 5 cycles after out_valid -> bcd stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-034 Reset mid-operation: rst asserted 3 cycles into SHIFT -> next cycle state IDLE, out_valid 0, bcd 0; fresh bin=42 then converts to 8'h42.
REQ-035 BIN_W=10,NDIG=4: bin=1023 -> bcd=16'h1023, out_valid 10 cycles after acceptance; back-to-back inputs achieve one result per BIN_W+2 cycles.
